// File: rtl/uart_word_rx.sv
// uart_sm_rx: UART byte receiver, 8N1, LSB first, CLKS_PER_BIT clocks per bit.
// Latency: byte_end pulses 1 clk after the middle of the stop bit (plus 2 clk input sync).
// Backpressure: none; byte_out/byte_end must be consumed in the byte_end cycle.
// Ports: clk, reset (sync, active-high), rx (idle high) -> byte_out, byte_end (1-clk pulse).
module uart_sm_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_end
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

    rstate_t          state_q, state_d;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             end_d;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        end_d   = 1'b0;
        case (state_q)
            R_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rx_sync) state_d = R_START;
            end
            // Re-check the line at mid start bit so a glitch does not start a frame.
            R_START: begin
                if (tick_q == HALF_BIT) begin
                    tick_d  = '0;
                    state_d = rx_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (tick_q == BIT_LAST) begin
                    tick_d  = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = R_STOP;
                end
            end
            // A low stop bit is a framing error: the byte is silently discarded.
            R_STOP: begin
                if (tick_q == BIT_LAST) begin
                    tick_d  = '0;
                    end_d   = rx_sync;
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= R_IDLE;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            byte_out <= '0;
            byte_end <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            byte_end <= end_d;
            if (end_d) byte_out <= shift_q;
        end
    end
endmodule

// uart_word_rx: assembles NUM_BYTES UART bytes into one word on a valid/ready output port.
// Latency: data_valid rises 2 clk after the last byte's byte_end (S_DONE, then output register).
// Backpressure: never stalls the line; one word is held, later words dropped with sticky overflow.
// Ports: clk, reset (sync, active-high), rx (idle high); data_out/data_valid/data_ready handshake;
//        byte_count partial-word progress; timeout_err 1-clk pulse; overflow sticky until reset.
module uart_word_rx #(
    parameter  int NUM_BYTES      = 4,
    parameter  int BIG_ENDIAN     = 0,
    parameter  int TIMEOUT_CYCLES = 0,
    localparam int DATA_W         = 8 * NUM_BYTES,
    localparam int CNT_W          = $clog2(NUM_BYTES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [CNT_W-1:0]  byte_count,
    output logic              timeout_err,
    output logic              overflow
);
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [CNT_W-1:0]  count_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              timeout_d;
    logic              offer;
    logic [7:0]        byte_out;
    logic              byte_end;

    uart_sm_rx u_byte_rx (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .byte_out (byte_out),
        .byte_end (byte_end)
    );

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        count_d   = byte_count;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        offer     = 1'b0;
        case (state_q)
            S_IDLE: begin
                asm_d   = '0;
                count_d = '0;
                timer_d = '0;
                state_d = S_RECV;
            end
            S_RECV: begin
                // byte_end takes priority over an expiring timer in the same cycle.
                if (byte_end) begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (byte_count == CNT_W'((BIG_ENDIAN != 0) ? (NUM_BYTES - 1 - i) : i))
                            asm_d[8*i +: 8] = byte_out;
                    end
                    count_d = byte_count + 1'b1;
                    timer_d = '0;
                    if (byte_count == LAST_SLOT) state_d = S_DONE;
                end else if ((TIMEOUT_CYCLES > 0) && (byte_count != '0)) begin
                    if (timer_q == TMR_LIMIT) begin
                        timeout_d = 1'b1;
                        count_d   = '0;
                        timer_d   = '0;
                        state_d   = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                offer   = 1'b1;
                asm_d   = '0;
                count_d = '0;
                timer_d = '0;
                state_d = S_RECV;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            asm_q       <= '0;
            byte_count  <= '0;
            timer_q     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            byte_count  <= count_d;
            timer_q     <= timer_d;
            timeout_err <= timeout_d;
        end
    end

    // Single-entry output register: a held word is only replaced when it transfers
    // in the same cycle, so data_out never moves under a stalled consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (offer) begin
            if (!data_valid || data_ready) begin
                data_out   <= asm_q;
                data_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_word_rx.sv
module tb_uart_word_rx;
    typedef logic [31:0] word_t;

    logic        clk = 1'b0;
    logic        reset, rx, rdy_a, rdy_o;
    logic [31:0] dout_a, dout_b;
    logic [15:0] dout_c;
    logic        vld_a, vld_b, vld_c, tmo_a, tmo_b, tmo_c, ov_a, ov_b, ov_c;
    logic [2:0]  bc_a, bc_b;
    logic [1:0]  bc_c;

    always #5 clk = ~clk;

    uart_word_rx #(.NUM_BYTES(4), .BIG_ENDIAN(0), .TIMEOUT_CYCLES(1000)) dut_a (
        .clk(clk), .reset(reset), .rx(rx), .data_out(dout_a), .data_valid(vld_a),
        .data_ready(rdy_a), .byte_count(bc_a), .timeout_err(tmo_a), .overflow(ov_a));
    uart_word_rx #(.NUM_BYTES(4), .BIG_ENDIAN(1), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .rx(rx), .data_out(dout_b), .data_valid(vld_b),
        .data_ready(rdy_o), .byte_count(bc_b), .timeout_err(tmo_b), .overflow(ov_b));
    uart_word_rx #(.NUM_BYTES(2), .BIG_ENDIAN(0), .TIMEOUT_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .rx(rx), .data_out(dout_c), .data_valid(vld_c),
        .data_ready(rdy_o), .byte_count(bc_c), .timeout_err(tmo_c), .overflow(ov_c));

    word_t      obs_dout [3];
    logic [2:0] obs_vld, obs_rdy, obs_ov;
    assign obs_dout[0] = dout_a;
    assign obs_dout[1] = dout_b;
    assign obs_dout[2] = {16'h0, dout_c};
    assign obs_vld = {vld_c, vld_b, vld_a};
    assign obs_rdy = {rdy_o, rdy_o, rdy_a};
    assign obs_ov  = {ov_c, ov_b, ov_a};

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- reference model: byte stream -> words -> one-deep holding slot
    int    NB [3] = '{4, 4, 2};
    bit    BE [3] = '{1'b0, 1'b1, 1'b0};
    word_t m_acc [3];
    int    m_cnt [3];
    word_t m_held [3];
    bit    m_held_v [3];
    bit    m_ov [3];
    bit    m_rdy [3];
    word_t exp_q [3][$];
    int    chk_idx [3] = '{0, 0, 0};

    function automatic void m_word(int d, word_t w);
        if (m_rdy[d]) begin
            if (m_held_v[d]) exp_q[d].push_back(m_held[d]);
            exp_q[d].push_back(w);
            m_held_v[d] = 1'b0;
        end else if (m_held_v[d]) begin
            m_ov[d] = 1'b1;
        end else begin
            m_held[d]   = w;
            m_held_v[d] = 1'b1;
        end
    endfunction

    function automatic void m_byte(logic [7:0] b);
        for (int d = 0; d < 3; d++) begin
            if (BE[d]) m_acc[d] = (m_acc[d] << 8) | word_t'(b);
            else       m_acc[d] = m_acc[d] | (word_t'(b) << (8 * m_cnt[d]));
            m_cnt[d]++;
            if (m_cnt[d] == NB[d]) begin
                m_word(d, m_acc[d]);
                m_acc[d] = '0;
                m_cnt[d] = 0;
            end
        end
    endfunction

    function automatic void m_ready(int d, bit v);
        m_rdy[d] = v;
        if (v && m_held_v[d]) begin
            exp_q[d].push_back(m_held[d]);
            m_held_v[d] = 1'b0;
        end
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 3; d++) begin
            m_acc[d] = '0; m_cnt[d] = 0; m_held_v[d] = 1'b0; m_ov[d] = 1'b0;
        end
    endfunction

    // ---------------- monitor: transfers, hold stability, latency, timeout pulses
    word_t got_q [3][$];
    word_t prev_dout [3];
    logic [2:0] prev_vld = '0, prev_rdy = '0;
    logic  prev_rst = 1'b1, prev_tmo = 1'b0;
    int    cyc = 0, done_cyc = 0, last_lat = -1;
    int    stab_n = 0, stab_bad = 0, tmo_rise = 0, tmo_long = 0;

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (!prev_rst && prev_vld[d] && !prev_rdy[d]) begin
                stab_n++;
                if (obs_dout[d] !== prev_dout[d]) stab_bad++;
            end
            if (!reset && obs_vld[d] && obs_rdy[d]) got_q[d].push_back(obs_dout[d]);
            prev_dout[d] = obs_dout[d];
        end
        if (bc_a == 3'd4) done_cyc = cyc;
        if (vld_a && !prev_vld[0]) last_lat = cyc - done_cyc;
        if (tmo_a) begin
            if (prev_tmo) tmo_long++;
            else          tmo_rise++;
        end
        prev_tmo = tmo_a;
        prev_vld = obs_vld;
        prev_rdy = obs_rdy;
        prev_rst = reset;
    end

    // ---------------- helpers
    task automatic chk(input string tag, input word_t obs, input word_t expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic word_t got_at(int d, int i);
        if (i >= 0 && i < got_q[d].size()) return got_q[d][i];
        return 'x;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] b);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(16);
        end
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        send_bits(b);
        tick(16 + gap);
        m_byte(b);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout_a"}, dout_a, 0);
        chk({tag, "_dout_b"}, dout_b, 0);
        chk({tag, "_dout_c"}, {16'h0, dout_c}, 0);
        chk({tag, "_vld"}, {29'h0, obs_vld}, 0);
        chk({tag, "_bcnt"}, {24'h0, bc_c, bc_b, bc_a}, 0);
        chk({tag, "_tmo_ov"}, {26'h0, tmo_c, tmo_b, tmo_a, obs_ov}, 0);
    endtask

    task automatic check_queues(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_nxfer%0d", tag, d), got_q[d].size(), exp_q[d].size());
            for (int i = chk_idx[d]; i < exp_q[d].size(); i++)
                chk($sformatf("%s_word%0d_%0d", tag, d, i), got_at(d, i), exp_q[d][i]);
            chk_idx[d] = exp_q[d].size();
        end
    endtask

    task automatic check_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_vld%0d", tag, d), obs_vld[d], m_held_v[d]);
            chk($sformatf("%s_ov%0d", tag, d), obs_ov[d], m_ov[d]);
            if (m_held_v[d]) chk($sformatf("%s_held%0d", tag, d), obs_dout[d], m_held[d]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w1, w2;
        int    tmo0, n0;
        bit    found;
        logic [7:0] rb;
        rx = 1'b1; reset = 1'b1; rdy_a = 1'b1; rdy_o = 1'b1;
        for (int d = 0; d < 3; d++) m_ready(d, 1'b1);
        m_reset();
        tick(3);
        chk_zero("reset");
        reset = 1'b0;
        tick(20);

        // Directed word, all consumers ready.
        send_byte(8'h78, 4); send_byte(8'h56, 4); send_byte(8'h34, 4); send_byte(8'h12, 4);
        tick(10);
        check_queues("t1");
        chk("t1_le_word", got_at(0, 0), 32'h12345678);
        chk("t1_be_word", got_at(1, 0), 32'h78563412);
        chk("t1_2byte_words", {got_at(2, 0)[15:0], got_at(2, 1)[15:0]}, 32'h56781234);
        chk("t1_latency", last_lat, 1);
        chk("t1_no_timeout", tmo_rise, 0);
        check_state("t1");

        // Random words with random inter-byte gaps.
        for (int k = 0; k < 6; k++)
            for (int j = 0; j < 4; j++) send_byte(8'($urandom), $urandom_range(2, 40));
        tick(10);
        check_queues("t2");
        check_state("t2");

        // Partial word abandoned longer than the timeout.
        send_byte(8'h11, 4); send_byte(8'h22, 4);
        tmo0 = tmo_rise;
        tick(1100);
        chk("t3_tmo_pulses", tmo_rise - tmo0, 1);
        chk("t3_tmo_width", tmo_long, 0);
        chk("t3_bcnt_a", bc_a, 0);
        chk("t3_bcnt_b_no_timeout", bc_b, 2);
        m_acc[0] = '0; m_cnt[0] = 0;
        send_byte(8'hDD, 4); send_byte(8'hCC, 4); send_byte(8'hBB, 4); send_byte(8'hAA, 4);
        tick(10);
        chk("t3_word_a", got_at(0, got_q[0].size() - 1), 32'hAABBCCDD);
        check_queues("t3");

        // Reset mid-word, with a word held in the 2-byte receiver.
        rdy_o = 1'b0; m_ready(1, 1'b0); m_ready(2, 1'b0);
        for (int j = 0; j < 3; j++) send_byte(8'($urandom), 4);
        chk("t6_bcnt_a", bc_a, 3);
        chk("t6_held_c", vld_c, 1);
        reset = 1'b1;
        tick(1);
        chk_zero("t6_rst");
        reset = 1'b0; m_reset();
        rdy_o = 1'b1; m_ready(1, 1'b1); m_ready(2, 1'b1);
        tick(5);
        for (int j = 0; j < 4; j++) send_byte(8'($urandom), 4);
        tick(10);
        check_queues("t6");
        check_state("t6");

        // Stalled consumers: second word dropped, overflow set.
        rdy_a = 1'b0; rdy_o = 1'b0;
        for (int d = 0; d < 3; d++) m_ready(d, 1'b0);
        for (int j = 1; j <= 8; j++) send_byte(8'(j), 4);
        tick(10);
        chk("t4_held_a", dout_a, 32'h04030201);
        chk("t4_held_b", dout_b, 32'h01020304);
        chk("t4_ov_a", ov_a, 1);
        check_state("t4");
        n0 = got_q[0].size();
        rdy_a = 1'b1; rdy_o = 1'b1;
        for (int d = 0; d < 3; d++) m_ready(d, 1'b1);
        tick(5);
        chk("t4_one_xfer", got_q[0].size() - n0, 1);
        chk("t4_vld_a_clr", vld_a, 0);
        check_queues("t4");
        check_state("t4b");

        reset = 1'b1; tick(1); reset = 1'b0; m_reset(); tick(5);
        chk("rst_clears_ov", {29'h0, obs_ov}, 0);

        // Ready rises exactly in the S_DONE cycle of the second word.
        w1 = $urandom; w2 = $urandom;
        rdy_a = 1'b0; m_ready(0, 1'b0);
        for (int j = 0; j < 4; j++) send_byte(w1[8*j +: 8], 4);
        tick(5);
        chk("t5_w1_held", dout_a, w1);
        m_ready(0, 1'b1);
        for (int j = 0; j < 3; j++) send_byte(w2[8*j +: 8], 4);
        rb = w2[31:24];
        send_bits(rb);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (bc_a == 3'd4) begin
                rdy_a = 1'b1;
                found = 1'b1;
            end
        end
        chk("t5_done_seen", found, 1);
        tick(1);
        chk("t5_w2_loaded", dout_a, w2);
        chk("t5_vld_kept", vld_a, 1);
        chk("t5_no_ov", ov_a, 0);
        tick(30);
        m_byte(rb);
        check_queues("t5");
        check_state("t5");

        chk("hold_stable", stab_bad, 0);
        chk("hold_observed", stab_n > 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
